// File: rtl/super_pkg.sv
// Shared constants and types for the CHERI ALU issue arbiter.
package super_pkg;

    localparam int CHERI_ALU_TAG_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage : super_pkg

// File: rtl/cheri_alu_arb_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins, and a tie goes to ptr_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_i);

endmodule : rr_arb2

// File: rtl/cheri_alu_arb.sv
// Arbitrates two issue slots onto one CHERI ALU and holds the result until the consumer takes it.
//   state | meaning
//   IDLE  | result register empty, a grant may load it
//   HOLD  | result register holds an undelivered result (rsp_valid_o=1)
module cheri_alu_arb
    import super_pkg::*;
#(
    parameter int TagW   = CHERI_ALU_TAG_W,
    parameter int NumReq = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    input  logic [NumReq*TagW-1:0] req_tag_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic                   flush_i,
    output logic                   alu_en_o,
    output logic                   alu_sel_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_src_o,
    output logic [TagW-1:0]        rsp_tag_o,
    output logic [15:0]            stall_cnt_o
);

    arb_state_e      state_q, state_d;
    logic            rr_q, rr_d;
    logic            src_q, src_d;
    logic [TagW-1:0] tag_q, tag_d;
    logic [15:0]     stall_q, stall_d;

    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       slot_free;
    logic       grant_en;
    logic       grant_any;
    logic       sel;

    rr_arb2 u_rr_arb2 (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (gnt_raw)
    );

    always_comb begin
        slot_free = (state_q == IDLE) || rsp_ready_i;
        // Reset also masks grants so nothing is launched into the ALU while it clears.
        grant_en  = slot_free && !flush_i && !rst_i;
        gnt       = grant_en ? gnt_raw : 2'b00;
        grant_any = |(req_valid_i & gnt);
        sel       = gnt[1];

        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        tag_d   = tag_q;
        stall_d = stall_q;

        if (grant_any) begin
            state_d = HOLD;
            rr_d    = ~sel;
            src_d   = sel;
            tag_d   = sel ? req_tag_i[2*TagW-1:TagW] : req_tag_i[TagW-1:0];
        end else if ((state_q == HOLD) && rsp_ready_i) begin
            state_d = IDLE;
        end

        if (flush_i) begin
            state_d = IDLE;
        end

        if ((|req_valid_i) && !grant_any && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            src_q   <= 1'b0;
            tag_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            tag_q   <= tag_d;
            stall_q <= stall_d;
        end
    end

    assign req_ready_o = gnt;
    assign alu_en_o    = grant_any;
    assign alu_sel_o   = sel;
    assign rsp_valid_o = (state_q == HOLD);
    assign rsp_src_o   = src_q;
    assign rsp_tag_o   = tag_q;
    assign stall_cnt_o = stall_q;

endmodule : cheri_alu_arb

// File: tb/tb_cheri_alu_arb.sv
// Directed bench for cheri_alu_arb: expected results are queued at grant time and checked on delivery.
module tb_cheri_alu_arb;

    typedef struct packed {
        logic       src;
        logic [3:0] tag;
    } rsp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] req_valid_i = 2'b00;
    logic [7:0] req_tag_i = 8'h00;
    logic [1:0] req_ready_o;
    logic       flush_i = 1'b0;
    logic       alu_en_o;
    logic       alu_sel_o;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic       rsp_src_o;
    logic [3:0] rsp_tag_o;
    logic [15:0] stall_cnt_o;

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    cheri_alu_arb #(.TagW(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_tag_i   (req_tag_i),
        .req_ready_o (req_ready_o),
        .flush_i     (flush_i),
        .alu_en_o    (alu_en_o),
        .alu_sel_o   (alu_sel_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_src_o   (rsp_src_o),
        .rsp_tag_o   (rsp_tag_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered result must match the oldest queued expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk_i);
            #4;
            if (!rst_i && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual_src=%0h actual_tag=%0h expected=none",
                             rsp_src_o, rsp_tag_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_src", {31'd0, rsp_src_o}, {31'd0, e.src});
                    chk("rsp_tag", {28'd0, rsp_tag_o}, {28'd0, e.tag});
                end
            end
        end
    end

    // One clock of stimulus; exp_vld/exp_stall < 0 skip that check.
    task automatic cyc(input logic rst, input logic [1:0] v, input logic [3:0] t0,
                       input logic [3:0] t1, input logic rdy, input logic fl,
                       input logic [1:0] exp_rdy, input int exp_vld, input int exp_stall);
        rsp_t e;
        @(negedge clk_i);
        #1;
        rst_i       = rst;
        req_valid_i = v;
        req_tag_i   = {t1, t0};
        rsp_ready_i = rdy;
        flush_i     = fl;
        #2;
        chk("req_ready", {30'd0, req_ready_o}, {30'd0, exp_rdy});
        chk("alu_en", {31'd0, alu_en_o}, {31'd0, |exp_rdy});
        chk("alu_sel", {31'd0, alu_sel_o}, {31'd0, exp_rdy[1]});
        if (exp_vld >= 0) chk("rsp_valid", {31'd0, rsp_valid_o}, exp_vld);
        if (exp_stall >= 0) chk("stall_cnt", {16'd0, stall_cnt_o}, exp_stall);
        if (exp_rdy != 2'b00) begin
            e.src = exp_rdy[1];
            e.tag = exp_rdy[1] ? t1 : t0;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        // Reset with both requests pending: no grants while reset is high.
        cyc(1, 2'b11, 4'h1, 4'h2, 1, 0, 2'b00, -1, -1);
        cyc(1, 2'b11, 4'h1, 4'h2, 1, 0, 2'b00,  0,  0);

        // Continuous contention with a ready consumer alternates 0,1,0,1.
        cyc(0, 2'b11, 4'h1, 4'h2, 1, 0, 2'b01, 0, 0);
        cyc(0, 2'b11, 4'h1, 4'h2, 1, 0, 2'b10, 1, 0);
        cyc(0, 2'b11, 4'h1, 4'h2, 1, 0, 2'b01, 1, 0);
        cyc(0, 2'b11, 4'h1, 4'h2, 1, 0, 2'b10, 1, 0);
        cyc(0, 2'b00, 4'h0, 4'h0, 1, 0, 2'b00, 1, 0);

        // req0 tag 5 granted, then held for 3 cycles while req1 waits.
        cyc(0, 2'b11, 4'h5, 4'hA, 1, 0, 2'b01, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b10, 4'h0, 4'hA, 0, 0, 2'b00, 1, i);
            chk("hold_tag", {28'd0, rsp_tag_o}, 32'h5);
        end

        // Same-cycle drain and refill from req1 with tag A.
        cyc(0, 2'b10, 4'h0, 4'hA, 1, 0, 2'b10, 1, 3);

        // Flush in HOLD: no grant, result dropped, pointer unchanged.
        cyc(0, 2'b11, 4'h3, 4'h4, 0, 1, 2'b00, 1, 3);
        chk("refill_tag", {28'd0, rsp_tag_o}, 32'hA);
        void'(exp_q.pop_back());
        cyc(0, 2'b11, 4'h3, 4'h4, 1, 0, 2'b01, 0, 4);
        cyc(0, 2'b11, 4'h3, 4'h4, 1, 0, 2'b10, 1, 4);
        cyc(0, 2'b00, 4'h0, 4'h0, 1, 0, 2'b00, 1, 4);

        // Reset in HOLD with requests pending; req0 wins first post-reset contention.
        cyc(0, 2'b01, 4'h7, 4'h8, 0, 0, 2'b01, 0, 4);
        cyc(1, 2'b11, 4'h7, 4'h8, 0, 0, 2'b00, 1, 4);
        void'(exp_q.pop_back());
        cyc(0, 2'b11, 4'h9, 4'hB, 1, 0, 2'b01, 0, 0);
        cyc(0, 2'b00, 4'h0, 4'h0, 1, 0, 2'b00, 1, 0);

        // Stall counter saturation.
        for (int i = 0; i < 65534; i++) begin
            cyc(0, 2'b11, 4'h0, 4'h0, 0, 1, 2'b00, -1, -1);
        end
        cyc(0, 2'b11, 4'h0, 4'h0, 0, 1, 2'b00, 0, 16'hFFFE);
        cyc(0, 2'b11, 4'h0, 4'h0, 0, 1, 2'b00, 0, 16'hFFFF);
        cyc(0, 2'b11, 4'h0, 4'h0, 0, 1, 2'b00, 0, 16'hFFFF);
        cyc(0, 2'b00, 4'h0, 4'h0, 0, 0, 2'b00, 0, 16'hFFFF);

        @(negedge clk_i);
        @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cheri_alu_arb
